// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared configuration for the rename-aware register file:
//                ROB index width, ROB depth, register count and data width.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_file_pkg;

    localparam int ROB_LOG_DEFAULT = 4;
    localparam int ROB_SIZE        = 1 << ROB_LOG_DEFAULT;
    localparam int NUM_REGS        = 32;
    localparam int REG_IDX_W       = 5;
    localparam int XLEN            = 32;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : Architectural register file with per-register rename tags.
//                Tracks which ROB entry will produce each register, serves
//                two combinational operand queries with commit bypass, and
//                drops all rename tags on a flush.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ROB_LOG = ROB_LOG_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 commit_enable,
    input  logic [REG_IDX_W-1:0] commit_index,
    input  logic [ROB_LOG-1:0]   commit_rob_id,
    input  logic [XLEN-1:0]      commit_value,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_dest,
    input  logic [ROB_LOG-1:0]   issue_rob_id,
    input  logic [REG_IDX_W-1:0] query_rs1,
    input  logic [REG_IDX_W-1:0] query_rs2,
    output logic [XLEN-1:0]      rs1_value,
    output logic [XLEN-1:0]      rs2_value,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_LOG-1:0]   rs1_rob_id,
    output logic [ROB_LOG-1:0]   rs2_rob_id
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ROB_LOG-1:0]  tag_q  [NUM_REGS];
    logic [ROB_LOG-1:0]  tag_d  [NUM_REGS];

    logic w_commit_go;
    logic w_issue_go;

    // Commit writes even during a flush; issue is dropped by a flush because
    // the renamed instruction is on the squashed path.
    assign w_commit_go = rdy && commit_enable && (commit_index != '0);
    assign w_issue_go  = rdy && issue_valid && (issue_dest != '0) && !flush;

    // Next-state: reset, then flush, then commit, then issue (issue wins on
    // a same-register collision because it is applied last).
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
                tag_d[i]  = '0;
            end
            busy_d = '0;
        end else begin
            if (flush) begin
                busy_d = '0;
            end
            if (w_commit_go) begin
                regs_d[commit_index] = commit_value;
                if (!flush && busy_q[commit_index] &&
                    (tag_q[commit_index] == commit_rob_id)) begin
                    busy_d[commit_index] = 1'b0;
                end
            end
            if (w_issue_go) begin
                busy_d[issue_dest] = 1'b1;
                tag_d[issue_dest]  = issue_rob_id;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
        tag_q  <= tag_d;
    end

    // Operand read: returns {busy, rob_id, value}. x0 is hard-wired to zero;
    // a commit resolving the pending tag this cycle is forwarded directly.
    function automatic logic [XLEN+ROB_LOG:0] read_operand(
        input logic [REG_IDX_W-1:0] rs
    );
        logic              f_busy;
        logic [ROB_LOG-1:0] f_rob;
        logic [XLEN-1:0]   f_val;
        f_busy = 1'b0;
        f_rob  = '0;
        f_val  = regs_q[rs];
        if (rs == '0) begin
            f_val = '0;
        end else if (busy_q[rs]) begin
            if (commit_enable && (commit_index == rs) &&
                (tag_q[rs] == commit_rob_id)) begin
                f_val = commit_value;
            end else begin
                f_busy = 1'b1;
                f_rob  = tag_q[rs];
            end
        end
        return {f_busy, f_rob, f_val};
    endfunction

    // Two independent query ports using the same read function.
    always_comb begin
        {rs1_busy, rs1_rob_id, rs1_value} = read_operand(query_rs1);
        {rs2_busy, rs2_rob_id, rs2_value} = read_operand(query_rs2);
    end

endmodule : reg_file
`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter ROB_LOG, default 4: ROB index width; the ROB holds 2^ROB_LOG entries.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global ready; low freezes issue and commit updates.
REQ-005 flush  input  1  ROB jump/mispredict; clears all rename tags.
REQ-006 commit_enable  input  1  ROB commit writes a register this cycle.
REQ-007 commit_index  input  5  architectural destination of the commit.
REQ-008 commit_rob_id  input  ROB_LOG  ROB entry being committed.
REQ-009 commit_value  input  32  committed result.
REQ-010 issue_valid  input  1  an instruction with a destination is issued this cycle.
REQ-011 issue_dest  input  5  destination register of the issued instruction.
REQ-012 issue_rob_id  input  ROB_LOG  ROB entry allocated to the issued instruction.
REQ-013 query_rs1, query_rs2  input  5 each  source register indices from issue.
REQ-014 rs1_value, rs2_value  output  32 each  operand value.
REQ-015 rs1_busy, rs2_busy  output  1 each  operand still pending in the ROB.
REQ-016 rs1_rob_id, rs2_rob_id  output  ROB_LOG each  producing ROB entry; valid when busy=1.

Function
REQ-017 State: 32 x 32-bit values, 32 busy bits, 32 ROB_LOG-bit tags.
REQ-018 x0: reads always give value 0 and busy 0; commits and issues to x0 are ignored.
REQ-019 Commit (rdy=1, commit_enable=1, index!=0): regs[index] <= commit_value next edge; busy[index] cleared only if busy=1 and tag==commit_rob_id.
REQ-020 Issue (rdy=1, issue_valid=1, dest!=0, flush=0): busy[dest] <= 1 and tag[dest] <= issue_rob_id next edge.
REQ-021 Same-cycle issue and commit to the same register: value is written, and busy=1 with tag=issue_rob_id afterwards (issue wins).
REQ-022 Flush: all busy bits cleared next edge, regardless of rdy; values are retained; an issue in the flush cycle is discarded.
REQ-023 Commit in the flush cycle (rdy=1) still writes its value.
REQ-024 Queries are combinational, zero latency: busy=0 gives value=regs[rs], rob_id=0; busy=1 gives busy=1, rob_id=tag[rs], value=regs[rs].
REQ-025 Commit bypass: if commit_enable=1, commit_index==rs!=0, busy[rs]=1 and tag[rs]==commit_rob_id, the query returns busy=0 and value=commit_value in the same cycle.
REQ-026 A same-cycle issue does not affect query outputs; issue orders source reads before its own destination rename.
REQ-027 rdy=0: issue and commit ignored, state held; flush and rst still act.
REQ-028 Priority: rst > flush > (commit, issue).

Reset
REQ-029 On rst, all values, busy bits and tags go to 0 next edge, and rst overrides rdy.
REQ-030 After reset, every query output is 0 (value 0, busy 0, rob_id 0).
REQ-031 A rst asserted mid-operation discards pending issue and commit in that cycle.

Structure
REQ-032 ROB_LOG, ROB_SIZE and the register count (32) come from the shared config include; the block defines no local widths.
REQ-033 Single flat module, no sub-modules; query logic duplicates one combinational read function for rs1 and rs2.

Verification
REQ-034 After reset, query x5, x0 -> value 0, busy 0 on both ports.
REQ-035 Issue dest=x3, rob_id=2; next cycle query x3 -> busy=1, rob_id=2; commit x3, rob_id=2, value 0xDEADBEEF same cycle -> busy=0, value 0xDEADBEEF (bypass); next cycle busy=0, value 0xDEADBEEF.
REQ-036 Issue x4 with rob_id=1, then x4 with rob_id=5; commit x4, rob_id=1, value 7 -> x4 value 7, busy=1, tag 5.
REQ-037 Same cycle: issue x6 with rob_id=3 and commit x6 with rob_id=0, value 9 -> x6 value 9, busy=1, tag 3.
REQ-038 Busy x1 (tag 4) and x2 (tag 6); assert flush with commit x7=0x55 and issue x8 -> x1, x2, x8 not busy, x7=0x55, x1 and x2 keep old values.
REQ-039 Commit x0=0x1234 and issue x0 -> x0 reads value 0, busy 0; with rdy=0, commit x9=1 -> x9 unchanged.
